// File: rtl/uart_receiver_if.sv
// Host-facing bundle of the UART receiver: rate/enable/line in, byte and status out.
// rx_state mirrors the receiver FSM so checkers can bind to it.
interface uart_receiver_if;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_BUSY;
    logic [2:0] rx_state;

    modport master (
        output baud_select, Rx_EN, RxD,
        input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY, rx_state
    );

    modport slave (
        input  baud_select, Rx_EN, RxD,
        output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY, rx_state
    );
endinterface

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver for start + 8 data (LSB first) + even parity + stop frames.
// Status (VALID/PERROR/FERROR) is level-held until the next start, Rx_EN low or reset.
module uart_receiver #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_receiver_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic int calc_div(input int baud);
        int d;
        d = (CLK_HZ + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
        return (d < 1) ? 1 : d;
    endfunction

    localparam int DW = $clog2(calc_div(300) + 1);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    state_t        state, state_d;
    logic [DW-1:0] div_cnt, div_q, div_d, div_live, div_act;
    logic [TW-1:0] tick_cnt, tick_d;
    logic [2:0]    bit_cnt, bit_d;
    logic [7:0]    shift, shift_d, data, data_d;
    logic          perr, perr_d;
    logic          valid, valid_d, perror, perror_d, ferror, ferror_d, busy, busy_d;
    logic          rx_meta, rx_sync, rx_prev;
    logic          tick, fall;

    always_comb begin
        case (bus.baud_select)
            3'b000:  div_live = DW'(calc_div(300));
            3'b001:  div_live = DW'(calc_div(1200));
            3'b010:  div_live = DW'(calc_div(4800));
            3'b011:  div_live = DW'(calc_div(9600));
            3'b100:  div_live = DW'(calc_div(19200));
            3'b101:  div_live = DW'(calc_div(38400));
            3'b110:  div_live = DW'(calc_div(57600));
            default: div_live = DW'(calc_div(115200));
        endcase
    end

    // Rate is frozen for the whole frame once the start edge has been seen.
    assign div_act = (state == IDLE) ? div_live : div_q;
    assign tick    = bus.Rx_EN && (div_cnt >= div_act - 1'b1);
    assign fall    = rx_prev && !rx_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (!bus.Rx_EN || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.RxD;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div_q    <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            perr     <= 1'b0;
            data     <= '0;
            valid    <= 1'b0;
            perror   <= 1'b0;
            ferror   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            div_q    <= div_d;
            tick_cnt <= tick_d;
            bit_cnt  <= bit_d;
            shift    <= shift_d;
            perr     <= perr_d;
            data     <= data_d;
            valid    <= valid_d;
            perror   <= perror_d;
            ferror   <= ferror_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        state_d  = state;
        div_d    = div_q;
        tick_d   = tick_cnt;
        bit_d    = bit_cnt;
        shift_d  = shift;
        perr_d   = perr;
        data_d   = data;
        valid_d  = valid;
        perror_d = perror;
        ferror_d = ferror;
        busy_d   = busy;
        if (!bus.Rx_EN) begin
            state_d  = IDLE;
            tick_d   = '0;
            bit_d    = '0;
            valid_d  = 1'b0;
            perror_d = 1'b0;
            ferror_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall) begin
                        state_d  = START;
                        div_d    = div_live;
                        tick_d   = '0;
                        bit_d    = '0;
                        valid_d  = 1'b0;
                        perror_d = 1'b0;
                        ferror_d = 1'b0;
                        busy_d   = 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == MID) begin
                            tick_d = '0;
                            if (!rx_sync) begin
                                state_d = DATA;
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            tick_d = tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_cnt == LAST) begin
                            tick_d  = '0;
                            shift_d = {rx_sync, shift[7:1]};
                            bit_d   = bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                state_d = PARITY;
                            end
                        end else begin
                            tick_d = tick_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        if (tick_cnt == LAST) begin
                            tick_d  = '0;
                            perr_d  = rx_sync ^ (^shift);
                            state_d = STOP;
                        end else begin
                            tick_d = tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tick_cnt == LAST) begin
                            tick_d   = '0;
                            data_d   = shift;
                            perror_d = perr;
                            ferror_d = !rx_sync;
                            valid_d  = !perr && rx_sync;
                            busy_d   = 1'b0;
                            state_d  = IDLE;
                        end else begin
                            tick_d = tick_cnt + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.Rx_DATA   = data;
    assign bus.Rx_VALID  = valid;
    assign bus.Rx_PERROR = perror;
    assign bus.Rx_FERROR = ferror;
    assign bus.Rx_BUSY   = busy;
    assign bus.rx_state  = state;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus randomized frame stimulus for uart_receiver, checked against a
// frame-level model (bit time, parity by ones count) through an expected queue.
module tb_uart_receiver;
    localparam int CLK_HZ = 1_000_000;

    logic clk = 1'b0;
    logic reset;

    uart_receiver_if rx_if();

    uart_receiver #(.CLK_HZ(CLK_HZ), .OVERSAMPLE(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rx_if)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [10:0] exp_q[$];
    logic [7:0]  last_data;
    int          baud_tab[8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clock cycles per bit: 16 sample ticks, each round(CLK_HZ / (16 * baud)) clocks.
    function automatic int bit_clks(input logic [2:0] sel);
        real div;
        div = real'(CLK_HZ) / (16.0 * real'(baud_tab[sel]));
        if (div < 1.0) div = 1.0;
        return 16 * int'(div);
    endfunction

    // Expected status word {data, valid, perror, ferror} for one frame on the line.
    function automatic logic [10:0] model(input logic [7:0] b, input logic p, input logic s);
        logic perr;
        perr = ($countones({b, p}) % 2) != 0;
        return {b, !perr && s, perr, !s};
    endfunction

    task automatic check_status(input string tag);
        logic [10:0] e;
        e = exp_q.pop_front();
        check({tag, "_data"},   rx_if.Rx_DATA,   e[10:3]);
        check({tag, "_valid"},  rx_if.Rx_VALID,  e[2]);
        check({tag, "_perror"}, rx_if.Rx_PERROR, e[1]);
        check({tag, "_ferror"}, rx_if.Rx_FERROR, e[0]);
        check({tag, "_busy"},   rx_if.Rx_BUSY,   1'b0);
        last_data = e[10:3];
    endtask

    task automatic send_frame(input string tag, input logic [7:0] b, input logic flip_par,
                              input logic stop_val, input int bt, input int tog_bit,
                              input logic [2:0] tog_sel);
        logic [10:0] fr;
        logic        p;
        p  = (^b) ^ flip_par;
        fr = {stop_val, p, b, 1'b0};
        exp_q.push_back(model(b, p, stop_val));
        for (int i = 0; i < 11; i++) begin
            rx_if.RxD = fr[i];
            if (i == tog_bit) rx_if.baud_select = tog_sel;
            if (i == 5) begin
                repeat (bt / 2) @(negedge clk);
                check({tag, "_busy_mid"}, rx_if.Rx_BUSY, 1'b1);
                repeat (bt - bt / 2) @(negedge clk);
            end else begin
                repeat (bt) @(negedge clk);
            end
        end
        check_status(tag);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int          bt;
        logic [10:0] fr;
        logic [7:0]  rb;
        logic [2:0]  sel;
        int          kind;

        reset             = 1'b1;
        rx_if.RxD         = 1'b1;
        rx_if.Rx_EN       = 1'b1;
        rx_if.baud_select = 3'b111;
        last_data         = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_data",   rx_if.Rx_DATA,   8'h00);
        check("rst_valid",  rx_if.Rx_VALID,  1'b0);
        check("rst_perror", rx_if.Rx_PERROR, 1'b0);
        check("rst_ferror", rx_if.Rx_FERROR, 1'b0);
        check("rst_busy",   rx_if.Rx_BUSY,   1'b0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        bt = bit_clks(3'b111);
        send_frame("good_aa", 8'hAA, 1'b0, 1'b1, bt, -1, 3'b111);
        send_frame("good_55", 8'h55, 1'b0, 1'b1, bt, -1, 3'b111);
        send_frame("good_cc", 8'hCC, 1'b0, 1'b1, bt, -1, 3'b111);
        send_frame("good_89", 8'h89, 1'b0, 1'b1, bt, -1, 3'b111);
        send_frame("par_89",  8'h89, 1'b1, 1'b1, bt, -1, 3'b111);

        // Stop bit 0 followed by a long break: only one framing error may appear.
        send_frame("ferr_55", 8'h55, 1'b0, 1'b0, bt, -1, 3'b111);
        for (int i = 0; i < 20; i++) begin
            repeat (bt) @(negedge clk);
            check("break_busy", rx_if.Rx_BUSY, 1'b0);
        end
        rx_if.RxD = 1'b1;
        repeat (2 * bt) @(negedge clk);
        check("break_ferror_held", rx_if.Rx_FERROR, 1'b1);
        check("break_data_held",   rx_if.Rx_DATA,   8'h55);

        // Glitch of 4 sample ticks: start is taken, then rejected at mid start bit.
        rx_if.RxD = 1'b0;
        repeat (bt / 4) @(negedge clk);
        rx_if.RxD = 1'b1;
        repeat (2 * bt) @(negedge clk);
        check("glitch_busy",   rx_if.Rx_BUSY,   1'b0);
        check("glitch_valid",  rx_if.Rx_VALID,  1'b0);
        check("glitch_perror", rx_if.Rx_PERROR, 1'b0);
        check("glitch_ferror", rx_if.Rx_FERROR, 1'b0);
        check("glitch_data",   rx_if.Rx_DATA,   8'h55);
        send_frame("after_glitch", 8'hAA, 1'b0, 1'b1, bt, -1, 3'b111);

        for (int s = 7; s >= 0; s--) begin
            sel = 3'(s);
            rx_if.baud_select = sel;
            repeat (2) @(negedge clk);
            send_frame($sformatf("sweep_%0d", s), 8'hCC, 1'b0, 1'b1, bit_clks(sel),
                       (s == 5) ? 4 : -1, 3'b000);
        end

        for (int n = 0; n < 12; n++) begin
            sel  = 3'($urandom_range(5, 7));
            rb   = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 3);
            rx_if.baud_select = sel;
            bt = bit_clks(sel);
            repeat ($urandom_range(1, 20)) @(negedge clk);
            send_frame($sformatf("rand_%0d", n), rb, kind == 2, kind != 3, bt, -1, sel);
            if (kind == 3) begin
                rx_if.RxD = 1'b1;
                repeat (2 * bt) @(negedge clk);
            end
        end

        // Enable dropped in the middle of data bit 4 of 8'hAA.
        rx_if.baud_select = 3'b111;
        bt = bit_clks(3'b111);
        repeat (4) @(negedge clk);
        fr = {1'b1, 1'b0, 8'hAA, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx_if.RxD = fr[i];
            repeat (bt) @(negedge clk);
        end
        rx_if.RxD = fr[5];
        repeat (bt / 2) @(negedge clk);
        check("abort_busy_before", rx_if.Rx_BUSY, 1'b1);
        rx_if.Rx_EN = 1'b0;
        @(negedge clk);
        check("abort_busy",   rx_if.Rx_BUSY,   1'b0);
        check("abort_valid",  rx_if.Rx_VALID,  1'b0);
        check("abort_perror", rx_if.Rx_PERROR, 1'b0);
        check("abort_ferror", rx_if.Rx_FERROR, 1'b0);
        check("abort_data",   rx_if.Rx_DATA,   last_data);
        rx_if.RxD = 1'b1;
        repeat (2 * bt) @(negedge clk);
        rx_if.Rx_EN = 1'b1;
        repeat (2 * bt) @(negedge clk);
        check("reenable_busy", rx_if.Rx_BUSY, 1'b0);

        // Reset in the middle of an 8'h55 frame discards it.
        fr = {1'b1, 1'b0, 8'h55, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx_if.RxD = fr[i];
            repeat (bt) @(negedge clk);
        end
        check("rstmid_busy_before", rx_if.Rx_BUSY, 1'b1);
        reset = 1'b1;
        #1;
        check("rstmid_busy",   rx_if.Rx_BUSY,   1'b0);
        check("rstmid_data",   rx_if.Rx_DATA,   8'h00);
        check("rstmid_valid",  rx_if.Rx_VALID,  1'b0);
        check("rstmid_ferror", rx_if.Rx_FERROR, 1'b0);
        @(negedge clk);
        reset     = 1'b0;
        rx_if.RxD = 1'b1;
        repeat (2 * bt) @(negedge clk);
        send_frame("after_reset", 8'h55, 1'b0, 1'b1, bt, -1, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
